// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: two producer handshakes, decode issue/hazard
// signals, and the registered register-file write port with scoreboard.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    // ALU write-back producer
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;

    // Memory-load write-back producer
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;

    // Decode side
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_reg;
    logic [ADDR_W-1:0] read_reg_1;
    logic [ADDR_W-1:0] read_reg_2;
    logic              raw_hazard_1;
    logic              raw_hazard_2;

    // Register-file write port and scoreboard
    logic                  rf_reg_write;
    logic [ADDR_W-1:0]     rf_write_reg;
    logic [DATA_W-1:0]     rf_write_data;
    logic [2**ADDR_W-1:0]  pending;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  issue_valid, issue_reg, read_reg_1, read_reg_2,
        output alu_ready, mem_ready, issue_ready, raw_hazard_1, raw_hazard_2,
        output rf_reg_write, rf_write_reg, rf_write_data, pending
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output issue_valid, issue_reg, read_reg_1, read_reg_2,
        input  alu_ready, mem_ready, issue_ready, raw_hazard_1, raw_hazard_2,
        input  rf_reg_write, rf_write_reg, rf_write_data, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port,
// with a pending-write scoreboard for RAW/WAW hazard detection in decode.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic                  clk,
    input logic                  reset_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;

    typedef enum logic {GrantAlu, GrantMem} grant_e;

    grant_e               last_grant_q, last_grant_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [NumRegs-1:0]   pending_q, pending_d;
    logic                 alu_sel, mem_sel;
    logic                 issue_ok, issue_fire;

    // Ready selection: a lone requester always wins; on contention the side
    // not granted last time wins.
    always_comb begin
        alu_sel = 1'b0;
        mem_sel = 1'b0;
        if (bus.alu_valid && bus.mem_valid) begin
            alu_sel = (last_grant_q == GrantMem);
            mem_sel = ~alu_sel;
        end else begin
            alu_sel = bus.alu_valid;
            mem_sel = bus.mem_valid;
        end
    end

    assign bus.alu_ready = alu_sel;
    assign bus.mem_ready = mem_sel;

    // Register 0 is hardwired, so it can always be issued and never stalls.
    assign issue_ok        = ~pending_q[bus.issue_reg] | (bus.issue_reg == '0);
    assign issue_fire      = bus.issue_valid & issue_ok;
    assign bus.issue_ready = issue_ok;

    assign bus.raw_hazard_1 = pending_q[bus.read_reg_1];
    assign bus.raw_hazard_2 = pending_q[bus.read_reg_2];

    // Write stage next state: capture the granted requester; a write to
    // register 0 completes the handshake but is squashed.
    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_reg_d     = wr_reg_q;
        wr_data_d    = wr_data_q;
        if (alu_sel) begin
            last_grant_d = GrantAlu;
            if (bus.alu_reg != '0) begin
                wr_en_d   = 1'b1;
                wr_reg_d  = bus.alu_reg;
                wr_data_d = bus.alu_data;
            end
        end else if (mem_sel) begin
            last_grant_d = GrantMem;
            if (bus.mem_reg != '0) begin
                wr_en_d   = 1'b1;
                wr_reg_d  = bus.mem_reg;
                wr_data_d = bus.mem_data;
            end
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so a
    // coincident set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d[wr_reg_q] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[bus.issue_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset drops any accepted-but-uncommitted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GrantMem;
            wr_en_q      <= 1'b0;
            wr_reg_q     <= '0;
            wr_data_q    <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_reg_q     <= wr_reg_d;
            wr_data_q    <= wr_data_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.rf_reg_write  = wr_en_q;
    assign bus.rf_write_reg  = wr_reg_q;
    assign bus.rf_write_data = wr_data_q;
    assign bus.pending       = pending_q;
endmodule
